// File: rtl/router_input_port.sv
`default_nettype none
// ============================================================================
// Module   : router_input_port
// Purpose  : Mesh router input channel with two polarity-interleaved VC
//            buffers and XY route computation feeding a crossbar request.
// Revision : 1.0
// ============================================================================
module router_input_port #(
    parameter int DATA_W = 64,
    parameter int HOP_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              in_si,
    output logic              in_ri,
    input  logic [0:DATA_W-1] in_di,
    output logic [0:4]        out_req,
    input  logic              out_gnt,
    output logic [0:DATA_W-1] out_do,
    output logic              ovf_err
);

    localparam int c_DIR_X = 1;
    localparam int c_DIR_Y = 2;
    localparam int c_HX_LO = 8;
    localparam int c_HY_LO = 16;

    localparam logic [0:4] c_ROUTE_E = 5'b10000;
    localparam logic [0:4] c_ROUTE_W = 5'b01000;
    localparam logic [0:4] c_ROUTE_N = 5'b00100;
    localparam logic [0:4] c_ROUTE_S = 5'b00010;
    localparam logic [0:4] c_ROUTE_L = 5'b00001;

    localparam logic [HOP_W-1:0] c_HOP_ONE = HOP_W'(1);

    logic [1:0]        r_full;
    logic [0:DATA_W-1] r_data  [2];
    logic [0:4]        r_route [2];
    logic              r_ovf;

    logic              w_wr_vc;
    logic              w_rd_vc;
    logic              w_wr;
    logic              w_rd;
    logic              w_ovf;
    logic [HOP_W-1:0]  w_hop_x;
    logic [HOP_W-1:0]  w_hop_y;
    logic [0:DATA_W-1] w_data;
    logic [0:4]        w_route;

    assign w_wr_vc = polarity;
    assign w_rd_vc = ~polarity;

    assign w_wr  = in_si & ~r_full[w_wr_vc];
    assign w_ovf = in_si &  r_full[w_wr_vc];
    assign w_rd  = out_gnt & r_full[w_rd_vc];

    assign w_hop_x = in_di[c_HX_LO +: HOP_W];
    assign w_hop_y = in_di[c_HY_LO +: HOP_W];

    // XY routing: exhaust X hops first; only the consumed field is decremented.
    always_comb begin
        w_data  = in_di;
        w_route = c_ROUTE_L;
        if (w_hop_x != '0) begin
            w_route                   = in_di[c_DIR_X] ? c_ROUTE_W : c_ROUTE_E;
            w_data[c_HX_LO +: HOP_W]  = w_hop_x - c_HOP_ONE;
        end else if (w_hop_y != '0) begin
            w_route                   = in_di[c_DIR_Y] ? c_ROUTE_S : c_ROUTE_N;
            w_data[c_HY_LO +: HOP_W]  = w_hop_y - c_HOP_ONE;
        end
    end

    // Write and read always address opposite VCs, so both may fire together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full     <= '0;
            r_data[0]  <= '0;
            r_data[1]  <= '0;
            r_route[0] <= '0;
            r_route[1] <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_wr) begin
                r_full[w_wr_vc]  <= 1'b1;
                r_data[w_wr_vc]  <= w_data;
                r_route[w_wr_vc] <= w_route;
            end
            if (w_rd) begin
                r_full[w_rd_vc] <= 1'b0;
            end
            if (w_ovf) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign in_ri   = ~r_full[w_wr_vc];
    assign out_req = r_full[w_rd_vc] ? r_route[w_rd_vc] : '0;
    assign out_do  = r_full[w_rd_vc] ? r_data[w_rd_vc]  : '0;
    assign ovf_err = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_router_input_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_input_port
// Purpose  : Directed and randomized checks of router_input_port against a
//            field-level behavioural model of the two VC buffers.
// Revision : 1.0
// ============================================================================
module tb_router_input_port;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          polarity;
    logic          in_si;
    logic          in_ri;
    logic [0:DW-1] in_di;
    logic [0:4]    out_req;
    logic          out_gnt;
    logic [0:DW-1] out_do;
    logic          ovf_err;

    int checks = 0;
    int errors = 0;

    logic          m_full  [2];
    logic [0:DW-1] m_data  [2];
    logic [0:4]    m_route [2];
    logic          m_ovf;

    always #5 clk = ~clk;

    router_input_port #(.DATA_W(DW), .HOP_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .in_si    (in_si),
        .in_ri    (in_ri),
        .in_di    (in_di),
        .out_req  (out_req),
        .out_gnt  (out_gnt),
        .out_do   (out_do),
        .ovf_err  (ovf_err)
    );

    function automatic logic [0:DW-1] mk_pkt(input logic dx, input logic dy,
                                             input int hx, input int hy);
        logic [0:DW-1] p;
        p          = {$urandom, $urandom};
        p[1]       = dx;
        p[2]       = dy;
        p[8+:8]    = 8'(hx);
        p[16+:8]   = 8'(hy);
        return p;
    endfunction

    function automatic int rand_hop();
        case ($urandom % 4)
            0:       return 0;
            1:       return 1;
            2:       return 255;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    // Reference route from the packet fields: E/W while X hops remain, then N/S, else Local.
    function automatic logic [0:4] ref_route(input logic [0:DW-1] p);
        int hx = int'(p[8+:8]);
        int hy = int'(p[16+:8]);
        if (hx > 0) return p[1] ? 5'b01000 : 5'b10000;
        if (hy > 0) return p[2] ? 5'b00010 : 5'b00100;
        return 5'b00001;
    endfunction

    function automatic logic [0:DW-1] ref_data(input logic [0:DW-1] p);
        logic [0:DW-1] d = p;
        int hx = int'(p[8+:8]);
        int hy = int'(p[16+:8]);
        if (hx > 0)      d[8+:8]  = 8'(hx - 1);
        else if (hy > 0) d[16+:8] = 8'(hy - 1);
        return d;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            m_full[v]  = 1'b0;
            m_data[v]  = '0;
            m_route[v] = '0;
        end
        m_ovf = 1'b0;
    endtask

    // Advance one clock: update the model from pre-edge inputs, then flip polarity.
    task automatic tick();
        int  wv = polarity ? 1 : 0;
        int  rv = 1 - wv;
        logic rd_ok = out_gnt && m_full[rv];
        if (reset) begin
            if (in_si) begin
                if (!m_full[wv]) begin
                    m_full[wv]  = 1'b1;
                    m_data[wv]  = ref_data(in_di);
                    m_route[wv] = ref_route(in_di);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (rd_ok) m_full[rv] = 1'b0;
        end else begin
            model_reset();
        end
        @(posedge clk);
        #1;
        polarity = ~polarity;
        in_si    = 1'b0;
        out_gnt  = 1'b0;
        in_di    = {$urandom, $urandom};
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; polarity = 1'b0; in_si = 1'b0; out_gnt = 1'b0; in_di = '0;
        model_reset();
        #3;
        checks++; if (in_ri !== 1'b1) begin errors++; $display("FAIL reset_in_ri got %b exp 1", in_ri); end
        checks++; if (out_req !== 5'b00000) begin errors++; $display("FAIL reset_out_req got %b exp 00000", out_req); end
        checks++; if (out_do !== '0) begin errors++; $display("FAIL reset_out_do got %h exp 0", out_do); end
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_err); end
        // Writes attempted while reset is held must be discarded.
        in_si = 1'b1; in_di = mk_pkt(1'b0, 1'b0, 3, 3);
        @(posedge clk); #1 polarity = 1'b1;
        @(posedge clk);
        @(negedge clk); #2;
        reset = 1'b1; in_si = 1'b0; polarity = 1'b0;
        tick();
        checks++; if (in_ri !== 1'b1) begin errors++; $display("FAIL release_in_ri got %b exp 1", in_ri); end
        checks++; if (out_req !== 5'b00000) begin errors++; $display("FAIL release_out_req got %b exp 00000", out_req); end
        checks++; if (out_do !== '0) begin errors++; $display("FAIL release_out_do got %h exp 0", out_do); end
        tick();
        checks++; if (in_ri !== 1'b1 || out_req !== 5'b00000) begin errors++; $display("FAIL release2 got ri=%b req=%b exp ri=1 req=00000", in_ri, out_req); end
    endtask

    task automatic test_route_east();
        logic [0:DW-1] p;
        polarity = 1'b0;
        p = mk_pkt(1'b0, 1'b0, 3, 2);
        in_di = p; in_si = 1'b1;
        tick();
        checks++; if (out_req !== 5'b10000) begin errors++; $display("FAIL east_req got %b exp 10000", out_req); end
        checks++; if (out_do[8+:8] !== 8'd2) begin errors++; $display("FAIL east_hop_x got %0d exp 2", out_do[8+:8]); end
        checks++; if (out_do[16+:8] !== 8'd2) begin errors++; $display("FAIL east_hop_y got %0d exp 2", out_do[16+:8]); end
        checks++; if (out_do !== ref_data(p)) begin errors++; $display("FAIL east_data got %h exp %h", out_do, ref_data(p)); end
        checks++; if (in_ri !== 1'b1) begin errors++; $display("FAIL east_ri_vc1 got %b exp 1", in_ri); end
        out_gnt = 1'b1;
        tick();
        checks++; if (in_ri !== 1'b1) begin errors++; $display("FAIL east_freed got %b exp 1", in_ri); end
        checks++; if (out_req !== 5'b00000) begin errors++; $display("FAIL east_idle_req got %b exp 00000", out_req); end
    endtask

    task automatic test_route_south_local();
        logic [0:DW-1] p;
        logic [0:DW-1] q;
        polarity = 1'b0;
        p = mk_pkt(1'b0, 1'b1, 0, 1);
        q = p; q[16+:8] = 8'd0;
        in_di = p; in_si = 1'b1;
        tick();
        checks++; if (out_req !== 5'b00010) begin errors++; $display("FAIL south_req got %b exp 00010", out_req); end
        checks++; if (out_do !== q) begin errors++; $display("FAIL south_data got %h exp %h", out_do, q); end
        out_gnt = 1'b1;
        tick();
        p = mk_pkt(1'b1, 1'b1, 0, 0);
        in_di = p; in_si = 1'b1;
        tick();
        checks++; if (out_req !== 5'b00001) begin errors++; $display("FAIL local_req got %b exp 00001", out_req); end
        checks++; if (out_do !== p) begin errors++; $display("FAIL local_data got %h exp %h", out_do, p); end
        out_gnt = 1'b1;
        tick();
    endtask

    task automatic test_two_vcs();
        logic [0:DW-1] a;
        logic [0:DW-1] b;
        polarity = 1'b0;
        a = mk_pkt(1'b1, 1'b0, 1, 7);
        b = mk_pkt(1'b0, 1'b0, 0, 4);
        in_di = a; in_si = 1'b1;
        tick();
        in_di = b; in_si = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            logic [0:4]    er = polarity ? 5'b01000 : 5'b00100;
            logic [0:DW-1] ed = polarity ? ref_data(a) : ref_data(b);
            checks++; if (in_ri !== 1'b0) begin errors++; $display("FAIL alt_ri[%0d] got %b exp 0", i, in_ri); end
            checks++; if (out_req !== er) begin errors++; $display("FAIL alt_req[%0d] got %b exp %b", i, out_req, er); end
            checks++; if (out_do !== ed) begin errors++; $display("FAIL alt_data[%0d] got %h exp %h", i, out_do, ed); end
            tick();
        end
        // polarity is 0 here: the crossbar is reading VC1.
        out_gnt = 1'b1;
        tick();
        checks++; if (out_req !== 5'b01000 || in_ri !== 1'b1) begin errors++; $display("FAIL vc1_grant got req=%b ri=%b exp req=01000 ri=1", out_req, in_ri); end
        tick();
        checks++; if (out_req !== 5'b00000 || in_ri !== 1'b0) begin errors++; $display("FAIL vc1_empty got req=%b ri=%b exp req=00000 ri=0", out_req, in_ri); end
        tick();
        out_gnt = 1'b1;
        tick();
    endtask

    task automatic test_overflow();
        logic [0:DW-1] c;
        polarity = 1'b0;
        c = mk_pkt(1'b0, 1'b1, 0, 9);
        in_di = c; in_si = 1'b1;
        tick();
        tick();
        checks++; if (in_ri !== 1'b0) begin errors++; $display("FAIL ovf_pre_ri got %b exp 0", in_ri); end
        in_di = mk_pkt(1'b1, 1'b1, 5, 5); in_si = 1'b1;
        tick();
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf_err); end
        checks++; if (out_do !== ref_data(c) || out_req !== 5'b00010) begin errors++; $display("FAIL ovf_kept got %h/%b exp %h/00010", out_do, out_req, ref_data(c)); end
        out_gnt = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf_err); end
        checks++; if (out_req !== 5'b00000) begin errors++; $display("FAIL ovf_drained got %b exp 00000", out_req); end
    endtask

    task automatic test_back_to_back();
        logic [0:DW-1] e;
        logic [0:DW-1] f;
        logic [0:DW-1] g;
        polarity = 1'b0;
        e = mk_pkt(1'b1, 1'b0, 2, 0);
        f = mk_pkt(1'b0, 1'b0, 0, 255);
        g = mk_pkt(1'b0, 1'b1, 255, 1);
        in_di = e; in_si = 1'b1;
        tick();
        in_di = f; in_si = 1'b1; out_gnt = 1'b1;
        tick();
        checks++; if (in_ri !== 1'b1) begin errors++; $display("FAIL b2b_vc0_free got %b exp 1", in_ri); end
        checks++; if (out_req !== 5'b00100 || out_do !== ref_data(f)) begin errors++; $display("FAIL b2b_vc1 got %b/%h exp 00100/%h", out_req, out_do, ref_data(f)); end
        in_di = g; in_si = 1'b1;
        tick();
        checks++; if (in_ri !== 1'b0 || out_req !== 5'b10000) begin errors++; $display("FAIL b2b_both got ri=%b req=%b exp ri=0 req=10000", in_ri, out_req); end
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++; if (in_ri !== 1'b1 || out_req !== 5'b00000 || out_do !== '0) begin errors++; $display("FAIL async_clr got ri=%b req=%b do=%h exp 1/00000/0", in_ri, out_req, out_do); end
        polarity = ~polarity;
        #1;
        checks++; if (in_ri !== 1'b1 || out_req !== 5'b00000 || ovf_err !== 1'b0) begin errors++; $display("FAIL async_clr2 got ri=%b req=%b ovf=%b exp 1/00000/0", in_ri, out_req, ovf_err); end
        @(negedge clk); #2 reset = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int            rv = polarity ? 0 : 1;
            int            wv = 1 - rv;
            logic [0:4]    er;
            logic [0:DW-1] ed;
            in_di   = mk_pkt(1'($urandom), 1'($urandom), rand_hop(), rand_hop());
            in_si   = (n < 200) ? (($urandom % 2 == 1) && !m_full[wv]) : 1'($urandom);
            out_gnt = 1'($urandom);
            #1;
            er = m_full[rv] ? m_route[rv] : 5'b00000;
            ed = m_full[rv] ? m_data[rv]  : '0;
            checks++; if (in_ri !== !m_full[wv]) begin errors++; $display("FAIL rnd_ri[%0d] got %b exp %b", n, in_ri, !m_full[wv]); end
            checks++; if (out_req !== er) begin errors++; $display("FAIL rnd_req[%0d] got %b exp %b", n, out_req, er); end
            checks++; if (out_do !== ed) begin errors++; $display("FAIL rnd_data[%0d] got %h exp %h", n, out_do, ed); end
            checks++; if (ovf_err !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d] got %b exp %b", n, ovf_err, m_ovf); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_route_east();
        test_route_south_local();
        test_two_vcs();
        test_overflow();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/router_input_port.md
Name: router_input_port

Overview:
- One input channel of the mesh router; sits directly downstream of nic_mesh and consumes its net_so/net_ri/net_do link. Also used unchanged on router-to-router links.
- Holds one packet per virtual channel (VC0 even, VC1 odd) and performs XY route computation.
- Presents a one-hot output-port request to the crossbar arbiter.
- Even/odd polarity scheme: the external link writes VC[polarity]; the crossbar drains VC[~polarity].

Parameters:
- DATA_W, 64, packet width; bit 0 is MSB-side index ([0:DATA_W-1] ordering).
- HOP_W, 8, width of each hop-count field.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- polarity  input  1  global even/odd phase; toggles every cycle at top level.
- in_si  input  1  upstream send strobe; packet valid on in_di this cycle.
- in_ri  output  1  ready to upstream: VC[polarity] buffer empty.
- in_di  input  [0:DATA_W-1]  upstream packet.
- out_req  output  [0:4]  one-hot request: [0]=E, [1]=W, [2]=N, [3]=S, [4]=Local.
- out_gnt  input  1  crossbar grant for the current request.
- out_do  output  [0:DATA_W-1]  packet to crossbar, with hop field already decremented.
- ovf_err  output  1  sticky: in_si asserted while in_ri=0.

Behaviour:
- Packet fields:
  - bit 0 = VC tag, ignored for storage.
  - bit 1 = x dir (0 east, 1 west).
  - bit 2 = y dir (0 north, 1 south).
  - bits [8:15] = hop_x.
  - bits [16:23] = hop_y.
  - All other bits pass through untouched.
- State per VC v∈{0,1}: full[v], data[v] (DATA_W), route[v] (5-bit one-hot).
- Reset (reset=0, asynchronous): full[0..1]=0, data=0, route=0, ovf_err=0. Consequently in_ri=1, out_req=0, out_do=0. The reset takes effect immediately, even mid-transfer; any held packets are discarded.
- Write side, combinational ready: in_ri = ~full[polarity].
- Write: on a clk edge with in_si=1 and full[polarity]=0:
  - full[polarity]<=1.
  - data[polarity] <= in_di with the routed hop field decremented.
  - route[polarity] <= route computed from in_di.
- Route computation, XY:
  - hop_x≠0 → E if dir_x=0 else W; hop_x decremented by 1.
  - else hop_y≠0 → N if dir_y=0 else S; hop_y decremented by 1.
  - else Local; no field changes.
  - Only one field is ever decremented. No wrap: a zero field is never decremented.
- Illegal write (in_si=1 while full[polarity]=1): packet dropped, stored state unchanged, ovf_err<=1 (sticky until reset).
- Read side, combinational:
  - out_req = full[~polarity] ? route[~polarity] : 5'b0.
  - out_do = full[~polarity] ? data[~polarity] : 0.
- Read: on a clk edge with out_gnt=1 and full[~polarity]=1: full[~polarity]<=0.
  - out_gnt while no request is ignored.
  - out_gnt with out_req=0 never clears anything.
- Write and read in the same cycle always target different VCs, so they are independent and both take effect.
- Latency: a packet accepted at edge N, polarity p, is first requested in the cycle after edge N, when polarity becomes ~p. Minimum 1 cycle, input to out_req.
- A packet not granted waits in its buffer. It re-requests every second cycle, i.e. whenever polarity equals its VC complement.
- Its VC[p] stays full, so the upstream sees in_ri=0 at that polarity. This is the backpressure.
- No combinational path from in_si/in_di to out_req/out_do.

Test Plan:
1. Reset → in_ri=1, out_req=00000, out_do=0, ovf_err=0. Release reset mid-cycle → no spurious state.
2. polarity=0, in_si=1, in_di: hop_x=3, dir_x=0, hop_y=2 → next cycle (polarity=1) out_req=10000 and out_do hop_x=2, hop_y=2. Then out_gnt=1 → full[0] clears, and in_ri=1 at the next polarity=0.
3. hop_x=0, hop_y=1, dir_y=1 → out_req=00010 (S) and out_do hop_y=0. Then hop_x=0, hop_y=0 → out_req=00001 (Local) with the packet unchanged.
4. Write VC0 with no grant; write VC1 on the next cycle. Check that:
   - both requests alternate with polarity;
   - in_ri=0 at both polarities;
   - a grant on VC1 only frees VC1.
5. in_si=1 while in_ri=0 → packet dropped, stored data unchanged, ovf_err=1 and held until reset.
6. Same-cycle write of VC[p] and grant of VC[~p] → both complete. Assert reset with both VCs full → all cleared immediately.
